// File: rtl/nq_execute_pipe.sv
// nq_execute_pipe: pipelined NanoQuarter execute stage.
// Registered output stage with a valid/ready handshake, a one-shot redirect pulse
// for taken control flow, and an iterative shift-add MUL that runs for DATA_W cycles.
module nq_execute_pipe #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned PC_W    = 32,
   parameter int unsigned BOFF_W  = 5,
   parameter int unsigned SHAMT_W = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:0]          op,
   input  logic [2:0]          funct,
   input  logic [SHAMT_W-1:0]  shamt,
   input  logic [DATA_W-1:0]   reg1data,
   input  logic [DATA_W-1:0]   reg2data,
   input  logic [DATA_W/2-1:0] idata,
   input  logic [DATA_W/2-1:0] jtarget,
   input  logic [BOFF_W-1:0]   boffset,
   input  logic                memread,
   input  logic [DATA_W-1:0]   memdata,
   input  logic [PC_W-1:0]     pc_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   mmuxout,
   output logic                regwrite,
   output logic [PC_W-1:0]     pc_out,
   output logic                redirect
);

   localparam int unsigned IMM_W = DATA_W / 2;
   localparam int unsigned SH_W  = $clog2(DATA_W);
   localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t state, state_d;

   // Iterative multiplier context captured at accept
   logic [DATA_W-1:0]  mul_a, mul_b, mul_acc;
   logic [CNT_W-1:0]   mul_cnt;
   logic [SHAMT_W-1:0] mul_shamt;
   logic               mul_memread;
   logic [DATA_W-1:0]  mul_memdata;
   logic [PC_W-1:0]    mul_pc;

   // Next values of the output register
   logic               out_valid_d, regwrite_d, redirect_d;
   logic [DATA_W-1:0]  mmuxout_d;
   logic [PC_W-1:0]    pc_out_d;

   logic               out_free_c, accept_c, is_mul_c, mul_last_c, mul_step_c;
   logic [DATA_W-1:0]  r_res_c, imm_res_c, alu_c, mul_add_c, mul_res_c;
   logic [PC_W-1:0]    pc_plus2_c, next_pc_c;
   logic               taken_c, regwrite_c;
   logic [SH_W-1:0]    sh_amt_c;

   assign out_free_c = !out_valid || out_ready;
   assign in_ready   = (state == IDLE) && out_free_c && !flush;
   assign accept_c   = in_valid && in_ready;
   assign is_mul_c   = (op == 2'b00) && (funct == 3'b111);
   assign sh_amt_c   = reg2data[SH_W-1:0];

   assign mul_add_c  = mul_acc + (mul_b[0] ? mul_a : '0);
   assign mul_res_c  = mul_add_c << mul_shamt;
   assign mul_last_c = (mul_cnt == CNT_W'(DATA_W - 1));

   // Single-cycle R-type and I-type result
   always_comb begin
      r_res_c   = '0;
      imm_res_c = '0;
      alu_c     = '0;
      case (funct)
         3'b000:  r_res_c = ~(reg1data & reg2data);
         3'b001:  r_res_c = reg1data ^ reg2data;
         3'b010:  r_res_c = reg1data << sh_amt_c;
         3'b011:  r_res_c = reg1data >> sh_amt_c;
         3'b100:  r_res_c = DATA_W'($signed(reg1data) >>> sh_amt_c);
         3'b101:  r_res_c = reg1data + reg2data;
         3'b110:  r_res_c = reg1data - reg2data;
         default: r_res_c = '0;
      endcase
      case (funct)
         3'b000, 3'b010: imm_res_c = {idata, {IMM_W{1'b0}}};
         3'b001, 3'b011: imm_res_c = {{IMM_W{1'b0}}, idata};
         default:        imm_res_c = '0;
      endcase
      case (op)
         2'b00:   alu_c = r_res_c << shamt;
         2'b01:   alu_c = imm_res_c;
         default: alu_c = '0;
      endcase
   end

   // Next-PC resolution and taken detection
   always_comb begin
      pc_plus2_c = pc_in + PC_W'(2);
      next_pc_c  = pc_plus2_c;
      taken_c    = 1'b0;
      if (op == 2'b10 && funct == 3'b000) begin
         next_pc_c = pc_in + PC_W'(jtarget);
         taken_c   = 1'b1;
      end else if (op == 2'b10 && funct == 3'b001) begin
         next_pc_c = pc_in + PC_W'(reg1data);
         taken_c   = 1'b1;
      end else if (op == 2'b11 && reg1data != reg2data) begin
         next_pc_c = pc_in + {{(PC_W-BOFF_W){boffset[BOFF_W-1]}}, boffset};
         taken_c   = 1'b1;
      end
   end

   assign regwrite_c = (op == 2'b00) || (op == 2'b01 && funct <= 3'b001) || memread;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   // Next state and output-register load; flush wins over any load
   always_comb begin
      state_d     = state;
      mul_step_c  = 1'b0;
      out_valid_d = out_valid;
      mmuxout_d   = mmuxout;
      regwrite_d  = regwrite;
      pc_out_d    = pc_out;
      redirect_d  = 1'b0;
      if (flush) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid_d = 1'b0;
            mmuxout_d   = '0;
            regwrite_d  = 1'b0;
            pc_out_d    = '0;
         end
         case (state)
            IDLE: begin
               if (accept_c) begin
                  if (is_mul_c) begin
                     state_d = BUSY;
                  end else begin
                     out_valid_d = 1'b1;
                     mmuxout_d   = memread ? memdata : alu_c;
                     regwrite_d  = regwrite_c;
                     pc_out_d    = next_pc_c;
                     redirect_d  = taken_c;
                  end
               end
            end
            BUSY: begin
               if (!mul_last_c) begin
                  mul_step_c = 1'b1;
               end else if (out_free_c) begin
                  state_d     = IDLE;
                  out_valid_d = 1'b1;
                  mmuxout_d   = mul_memread ? mul_memdata : mul_res_c;
                  regwrite_d  = 1'b1;
                  pc_out_d    = mul_pc;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Output register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         mmuxout   <= '0;
         regwrite  <= 1'b0;
         pc_out    <= '0;
         redirect  <= 1'b0;
      end else begin
         out_valid <= out_valid_d;
         mmuxout   <= mmuxout_d;
         regwrite  <= regwrite_d;
         pc_out    <= pc_out_d;
         redirect  <= redirect_d;
      end
   end

   // Multiplier operands: capture at accept, one multiplier bit per BUSY cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_a       <= '0;
         mul_b       <= '0;
         mul_acc     <= '0;
         mul_cnt     <= '0;
         mul_shamt   <= '0;
         mul_memread <= 1'b0;
         mul_memdata <= '0;
         mul_pc      <= '0;
      end else if (accept_c && is_mul_c) begin
         mul_a       <= reg1data;
         mul_b       <= reg2data;
         mul_acc     <= '0;
         mul_cnt     <= '0;
         mul_shamt   <= shamt;
         mul_memread <= memread;
         mul_memdata <= memdata;
         mul_pc      <= pc_plus2_c;
      end else if (mul_step_c) begin
         mul_a   <= mul_a << 1;
         mul_b   <= mul_b >> 1;
         mul_acc <= mul_add_c;
         mul_cnt <= mul_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_nq_execute_pipe.sv
// Scoreboard bench for nq_execute_pipe: stimulus pushes expected results,
// a negedge monitor pops and compares each new output-register load.
module tb_nq_execute_pipe;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, memread, out_valid, out_ready;
   logic        regwrite, redirect;
   logic [1:0]  op, shamt;
   logic [2:0]  funct;
   logic [15:0] reg1data, reg2data, memdata, mmuxout;
   logic [7:0]  idata, jtarget;
   logic [4:0]  boffset;
   logic [31:0] pc_in, pc_out;

   typedef struct {
      logic [15:0] mm;
      logic        rw;
      logic [31:0] pc;
      logic        rd;
      bit          chk_data;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   bit   pv = 1'b0, pcons = 1'b0;

   nq_execute_pipe #(.DATA_W(16), .PC_W(32), .BOFF_W(5), .SHAMT_W(2)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .funct(funct), .shamt(shamt), .reg1data(reg1data), .reg2data(reg2data),
      .idata(idata), .jtarget(jtarget), .boffset(boffset), .memread(memread),
      .memdata(memdata), .pc_in(pc_in), .out_valid(out_valid), .out_ready(out_ready),
      .mmuxout(mmuxout), .regwrite(regwrite), .pc_out(pc_out), .redirect(redirect)
   );

   always #5 clk = ~clk;

   // Monitor: compare on the first cycle each new result sits in the output register
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && (!pv || pcons)) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: mmuxout=%h pc_out=%h with empty scoreboard", mmuxout, pc_out);
         end else begin
            e = sb.pop_front();
            if ((e.chk_data && mmuxout !== e.mm) || regwrite !== e.rw ||
                pc_out !== e.pc || redirect !== e.rd)
            begin
               errors++;
               $display("FAIL result: got mm=%h rw=%b pc=%h rd=%b expected mm=%h rw=%b pc=%h rd=%b",
                        mmuxout, regwrite, pc_out, redirect, e.mm, e.rw, e.pc, e.rd);
            end
         end
      end
      pv    = out_valid;
      pcons = out_valid && out_ready;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present one operation, wait (bounded) for accept, optionally push the expected result
   task automatic send(input logic [1:0] o, input logic [2:0] f, input logic [1:0] sa,
                       input logic [15:0] r1, input logic [15:0] r2, input logic [7:0] im,
                       input logic [7:0] jt, input logic [4:0] bo, input logic mr,
                       input logic [15:0] md, input logic [31:0] pc, input bit push,
                       input logic [15:0] emm, input logic erw, input logic [31:0] epc,
                       input logic erd, input bit echk);
      exp_t e;
      bit   ok = 1'b0;
      @(posedge clk); #1;
      op = o; funct = f; shamt = sa; reg1data = r1; reg2data = r2; idata = im;
      jtarget = jt; boffset = bo; memread = mr; memdata = md; pc_in = pc;
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready stayed 0 for pc %h", pc);
      end else if (push) begin
         e.mm = emm; e.rw = erw; e.pc = epc; e.rd = erd; e.chk_data = echk;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      int  n;
      bit  seen;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = '0; funct = '0; shamt = '0; reg1data = '0; reg2data = '0; idata = '0;
      jtarget = '0; boffset = '0; memread = 1'b0; memdata = '0; pc_in = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_mmuxout",   32'(mmuxout),   32'd0);
      chk("rst_pc_out",    pc_out,         32'd0);
      chk("rst_flags",     {30'd0, regwrite, redirect}, 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);

      // NAND with post-shift, one-cycle latency
      send(2'b00, 3'b000, 2'd1, 16'h080F, 16'h80F9, 8'h00, 8'h00, 5'd0, 1'b0, 16'h0, 32'h1000,
           1, 16'hFFEC, 1'b1, 32'h1002, 1'b0, 1);
      @(negedge clk);
      chk("nand_latency", 32'(out_valid), 32'd1);

      // MUL latency: in_ready low for DATA_W cycles, result with in_ready return
      send(2'b00, 3'b111, 2'd0, 16'h0003, 16'h0005, 8'h00, 8'h00, 5'd0, 1'b0, 16'h0, 32'h2000,
           1, 16'h000F, 1'b1, 32'h2002, 1'b0, 1);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) break;
         n++;
      end
      chk("mul_busy_cycles", 32'(n), 32'd16);
      chk("mul_out_valid", 32'(out_valid), 32'd1);

      // MUL wrap with post-shift
      send(2'b00, 3'b111, 2'd1, 16'hFFFF, 16'hFFFF, 8'h00, 8'h00, 5'd0, 1'b0, 16'h0, 32'h2100,
           1, 16'h0002, 1'b1, 32'h2102, 1'b0, 1);
      send(2'b00, 3'b111, 2'd0, 16'h1234, 16'h0100, 8'h00, 8'h00, 5'd0, 1'b0, 16'h0, 32'h2200,
           1, 16'h3400, 1'b1, 32'h2202, 1'b0, 1);

      // Remaining R-type functions
      send(2'b00, 3'b001, 2'd2, 16'h00FF, 16'h0F0F, 8'h00, 8'h00, 5'd0, 1'b0, 16'h0, 32'h2300,
           1, 16'h3FC0, 1'b1, 32'h2302, 1'b0, 1);
      send(2'b00, 3'b010, 2'd0, 16'h0001, 16'h0014, 8'h00, 8'h00, 5'd0, 1'b0, 16'h0, 32'h2400,
           1, 16'h0010, 1'b1, 32'h2402, 1'b0, 1);
      send(2'b00, 3'b011, 2'd0, 16'h8000, 16'h000F, 8'h00, 8'h00, 5'd0, 1'b0, 16'h0, 32'h2500,
           1, 16'h0001, 1'b1, 32'h2502, 1'b0, 1);
      send(2'b00, 3'b100, 2'd1, 16'h8000, 16'h0003, 8'h00, 8'h00, 5'd0, 1'b0, 16'h0, 32'h2600,
           1, 16'hE000, 1'b1, 32'h2602, 1'b0, 1);
      send(2'b00, 3'b110, 2'd0, 16'h0003, 16'h0005, 8'h00, 8'h00, 5'd0, 1'b0, 16'h0, 32'h2700,
           1, 16'hFFFE, 1'b1, 32'h2702, 1'b0, 1);

      // ADD held by out_ready=0 for 4 cycles
      @(posedge clk); #1 out_ready = 1'b0;
      send(2'b00, 3'b101, 2'd0, 16'h1234, 16'h0101, 8'h00, 8'h00, 5'd0, 1'b0, 16'h0, 32'h3000,
           1, 16'h1335, 1'b1, 32'h3002, 1'b0, 1);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_hold", {out_valid, in_ready, redirect, regwrite, 12'd0, mmuxout},
             {1'b1, 1'b0, 1'b0, 1'b1, 12'd0, 16'h1335});
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("stall_consumed", 32'(out_valid), 32'd0);

      // Taken JMP held: redirect must not re-pulse while stalled
      @(posedge clk); #1 out_ready = 1'b0;
      send(2'b10, 3'b000, 2'd0, 16'h0000, 16'h0000, 8'h00, 8'h10, 5'd0, 1'b0, 16'h0, 32'h0040,
           1, 16'h0000, 1'b0, 32'h0050, 1'b1, 0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("jmp_stall_redirect", {31'd0, redirect}, 32'd0);
         chk("jmp_stall_pc", pc_out, 32'h0050);
      end
      out_ready = 1'b1;

      // BNE taken / not taken, JR, non-jump J funct
      send(2'b11, 3'b000, 2'd0, 16'h7FFF, 16'h0001, 8'h00, 8'h00, 5'b11110, 1'b0, 16'h0, 32'h0100,
           1, 16'h0000, 1'b0, 32'h00FE, 1'b1, 0);
      @(negedge clk);
      @(negedge clk);
      chk("bne_pulse_len", {31'd0, redirect}, 32'd0);
      send(2'b11, 3'b000, 2'd0, 16'h0055, 16'h0055, 8'h00, 8'h00, 5'b11110, 1'b0, 16'h0, 32'h0100,
           1, 16'h0000, 1'b0, 32'h0102, 1'b0, 0);
      send(2'b10, 3'b001, 2'd0, 16'h0020, 16'h0000, 8'h00, 8'h00, 5'd0, 1'b0, 16'h0, 32'h0010,
           1, 16'h0000, 1'b0, 32'h0030, 1'b1, 0);
      send(2'b10, 3'b010, 2'd0, 16'h0020, 16'h0000, 8'h00, 8'hFF, 5'd0, 1'b0, 16'h0, 32'h0200,
           1, 16'h0000, 1'b0, 32'h0202, 1'b0, 0);

      // Immediates and memory data mux
      send(2'b01, 3'b001, 2'd0, 16'h0000, 16'h0000, 8'h88, 8'h00, 5'd0, 1'b0, 16'h0, 32'h0500,
           1, 16'h0088, 1'b1, 32'h0502, 1'b0, 1);
      send(2'b01, 3'b000, 2'd0, 16'h0000, 16'h0000, 8'h12, 8'h00, 5'd0, 1'b0, 16'h0, 32'h0600,
           1, 16'h1200, 1'b1, 32'h0602, 1'b0, 1);
      send(2'b01, 3'b011, 2'd0, 16'h0000, 16'h0000, 8'h34, 8'h00, 5'd0, 1'b0, 16'h0, 32'h0610,
           1, 16'h0034, 1'b0, 32'h0612, 1'b0, 1);
      send(2'b01, 3'b100, 2'd0, 16'h0000, 16'h0000, 8'h55, 8'h00, 5'd0, 1'b1, 16'hAFA0, 32'h0620,
           1, 16'hAFA0, 1'b1, 32'h0622, 1'b0, 1);

      // Flush five cycles into a MUL: no result, ready right after
      send(2'b00, 3'b111, 2'd0, 16'h0003, 16'h0005, 8'h00, 8'h00, 5'd0, 1'b0, 16'h0, 32'h4000,
           0, 16'h0, 1'b0, 32'h0, 1'b0, 0);
      repeat (4) @(posedge clk);
      #1 flush = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      chk("flush_blocks_accept", 32'(in_ready), 32'd0);
      @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush_in_ready", {30'd0, in_ready, out_valid}, 32'd2);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("flush_no_output", 32'(seen), 32'd0);

      // Reset while a result is held clears it immediately
      @(posedge clk); #1 out_ready = 1'b0;
      send(2'b00, 3'b101, 2'd0, 16'h0001, 16'h0001, 8'h00, 8'h00, 5'd0, 1'b0, 16'h0, 32'h0700,
           1, 16'h0002, 1'b1, 32'h0702, 1'b0, 1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("rst_async_clear", {out_valid, 15'd0, mmuxout}, 32'd0);
      @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;

      // Reset mid-MUL: no result afterwards
      send(2'b00, 3'b111, 2'd0, 16'h0007, 16'h0007, 8'h00, 8'h00, 5'd0, 1'b0, 16'h0, 32'h0800,
           0, 16'h0, 1'b0, 32'h0, 1'b0, 0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("rst_mul_no_output", 32'(seen), 32'd0);
      chk("rst_mul_in_ready", 32'(in_ready), 32'd1);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
